alu_sequencer: RTL and testbench

- Upstream stage of the A/D destination registers in the relay-computer register unit.
- On a start request it runs one ALU instruction:
  - selects the B and C registers onto its operand inputs and captures the operands;
  - computes one of eight 8-bit functions;
  - presents the result on alu_result and pulses the load strobe of the chosen destination (A or D);
  - latches the sign, carry and zero condition flags.
- The destination register captures alu_result while its ld strobe is high.

---
 rtl/alu_sequencer.sv | 155 +++++++++++++++
 tb/tb_alu_sequencer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// ALU instruction sequencer: fetches B/C operands, computes one of eight functions,
// and strobes the result into destination register A or D while latching S/C/Z flags.
module alu_sequencer #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [2:0]   func,
    input  logic         dest,
    input  logic [N-1:0] b_in,
    input  logic [N-1:0] c_in,
    output logic         sel_b,
    output logic         sel_c,
    output logic [N-1:0] alu_result,
    output logic         ld_a,
    output logic         ld_d,
    output logic         busy,
    output logic         done,
    output logic         flag_s,
    output logic         flag_c,
    output logic         flag_z
);

    localparam logic [2:0] F_ADD = 3'd0;
    localparam logic [2:0] F_INC = 3'd1;
    localparam logic [2:0] F_AND = 3'd2;
    localparam logic [2:0] F_OR  = 3'd3;
    localparam logic [2:0] F_XOR = 3'd4;
    localparam logic [2:0] F_NOT = 3'd5;
    localparam logic [2:0] F_SHL = 3'd6;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SEL     = 3'd1,
        COMPUTE = 3'd2,
        LOAD    = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t       state;
    logic [2:0]   func_q;
    logic         dest_q;
    logic [N-1:0] op_b;
    logic [N-1:0] op_c;
    logic         carry_q;

    logic [N:0]   sum;
    logic [N-1:0] res_nxt;
    logic         carry_nxt;

    // Function unit operating on the latched operands.
    always_comb begin
        sum       = '0;
        res_nxt   = '0;
        carry_nxt = 1'b0;
        case (func_q)
            F_ADD: begin
                sum       = {1'b0, op_b} + {1'b0, op_c};
                res_nxt   = sum[N-1:0];
                carry_nxt = sum[N];
            end
            F_INC: begin
                sum       = {1'b0, op_b} + (N+1)'(1);
                res_nxt   = sum[N-1:0];
                carry_nxt = sum[N];
            end
            F_AND: res_nxt = op_b & op_c;
            F_OR:  res_nxt = op_b | op_c;
            F_XOR: res_nxt = op_b ^ op_c;
            F_NOT: res_nxt = ~op_b;
            F_SHL: begin
                res_nxt   = {op_b[N-2:0], op_b[N-1]};
                carry_nxt = op_b[N-1];
            end
            default: begin
                res_nxt   = '0;
                carry_nxt = 1'b0;
            end
        endcase
    end

    // Sequencer; strobes default low and are raised one state ahead so they are registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            func_q     <= '0;
            dest_q     <= 1'b0;
            op_b       <= '0;
            op_c       <= '0;
            carry_q    <= 1'b0;
            alu_result <= '0;
            sel_b      <= 1'b0;
            sel_c      <= 1'b0;
            ld_a       <= 1'b0;
            ld_d       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            flag_s     <= 1'b0;
            flag_c     <= 1'b0;
            flag_z     <= 1'b0;
        end else begin
            sel_b <= 1'b0;
            sel_c <= 1'b0;
            ld_a  <= 1'b0;
            ld_d  <= 1'b0;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        func_q <= func;
                        dest_q <= dest;
                        sel_b  <= 1'b1;
                        sel_c  <= 1'b1;
                        busy   <= 1'b1;
                        state  <= SEL;
                    end
                end
                SEL: begin
                    op_b  <= b_in;
                    op_c  <= c_in;
                    state <= COMPUTE;
                end
                COMPUTE: begin
                    alu_result <= res_nxt;
                    carry_q    <= carry_nxt;
                    ld_a       <= ~dest_q;
                    ld_d       <= dest_q;
                    state      <= LOAD;
                end
                LOAD: begin
                    flag_s <= alu_result[N-1];
                    flag_c <= carry_q;
                    flag_z <= (alu_result == '0);
                    done   <= 1'b1;
                    state  <= DONE;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Destination strobes are exclusive and never overlap the operand bus enables.
    a_ld_onehot: assert property (@(posedge clk) disable iff (reset) !(ld_a && ld_d));
    a_no_contention: assert property (@(posedge clk) disable iff (reset)
                                      !((ld_a || ld_d) && (sel_b || sel_c)));

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: stimulus pushes expected results into a scoreboard,
// a negedge monitor pops and checks each destination load and the following flag update.
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [2:0] func;
    logic       dest;
    logic [7:0] b_in;
    logic [7:0] c_in;
    logic       sel_b, sel_c, ld_a, ld_d, busy, done;
    logic       flag_s, flag_c, flag_z;
    logic [7:0] alu_result;

    typedef struct packed {
        logic       d;
        logic [7:0] r;
        logic       s;
        logic       c;
        logic       z;
    } exp_t;

    exp_t sbq[$];
    exp_t pend;
    logic pend_valid = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    alu_sequencer #(.N(8)) dut (
        .clk(clk), .reset(reset), .start(start), .func(func), .dest(dest),
        .b_in(b_in), .c_in(c_in), .sel_b(sel_b), .sel_c(sel_c),
        .alu_result(alu_result), .ld_a(ld_a), .ld_d(ld_d), .busy(busy), .done(done),
        .flag_s(flag_s), .flag_c(flag_c), .flag_z(flag_z)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Monitor: each ld pulse pops one expectation; flags and done are checked the cycle after.
    always @(negedge clk) begin
        if (reset) begin
            pend_valid <= 1'b0;
        end else begin
            if (pend_valid) begin
                chk("mon_flag_s", 32'(flag_s), 32'(pend.s));
                chk("mon_flag_c", 32'(flag_c), 32'(pend.c));
                chk("mon_flag_z", 32'(flag_z), 32'(pend.z));
                chk("mon_done",   32'(done),   32'd1);
                pend_valid <= 1'b0;
            end
            if (ld_a || ld_d) begin
                chk("mon_ld_onehot", 32'(ld_a && ld_d), 32'd0);
                chk("mon_no_contention", 32'(sel_b || sel_c), 32'd0);
                if (sbq.size() == 0) begin
                    chk("mon_unexpected_ld", 32'd1, 32'd0);
                end else begin
                    pend = sbq.pop_front();
                    chk("mon_result", 32'(alu_result), 32'(pend.r));
                    chk("mon_ld_d",   32'(ld_d),       32'(pend.d));
                    pend_valid <= 1'b1;
                end
            end
        end
    end

    // Cycle 0 is the start cycle; checks cycles 1..4 and returns during cycle 4.
    task automatic follow(input logic d, input logic [7:0] r);
        @(posedge clk); #1;
        start = 1'b0;
        chk("c1_sel_b", 32'(sel_b), 32'd1);
        chk("c1_sel_c", 32'(sel_c), 32'd1);
        chk("c1_busy",  32'(busy),  32'd1);
        @(posedge clk); #1;
        func = 3'($urandom);
        dest = 1'($urandom);
        b_in = 8'($urandom);
        c_in = 8'($urandom);
        chk("c2_sel_b", 32'(sel_b), 32'd0);
        chk("c2_ld",    32'(ld_a | ld_d), 32'd0);
        @(posedge clk); #1;
        chk("c3_ld_a",  32'(ld_a), 32'(!d));
        chk("c3_ld_d",  32'(ld_d), 32'(d));
        chk("c3_result", 32'(alu_result), 32'(r));
        @(posedge clk); #1;
        chk("c4_done",  32'(done), 32'd1);
        chk("c4_ld",    32'(ld_a | ld_d), 32'd0);
        chk("c4_busy",  32'(busy), 32'd1);
    endtask

    task automatic run_op(input logic [2:0] f, input logic d, input logic [7:0] b, input logic [7:0] c,
                          input logic [7:0] r, input logic s, input logic cy, input logic z);
        @(posedge clk); #1;
        start = 1'b1; func = f; dest = d; b_in = b; c_in = c;
        sbq.push_back('{d: d, r: r, s: s, c: cy, z: z});
        follow(d, r);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_result"}, 32'(alu_result), 32'd0);
        chk({tag, "_strobes"}, 32'({sel_b, sel_c, ld_a, ld_d, busy, done}), 32'd0);
        chk({tag, "_flags"}, 32'({flag_s, flag_c, flag_z}), 32'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; func = '0; dest = 1'b0; b_in = '0; c_in = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk_all_zero("reset_idle");

        //      func  dest  b      c      result S     C     Z
        run_op(3'd0, 1'b0, 8'h7F, 8'h01, 8'h80, 1'b1, 1'b0, 1'b0);  // ADD -> A
        run_op(3'd0, 1'b1, 8'hFF, 8'h01, 8'h00, 1'b0, 1'b1, 1'b1);  // ADD -> D, carry out
        run_op(3'd6, 1'b0, 8'h81, 8'h00, 8'h03, 1'b0, 1'b1, 1'b0);  // SHL rotate
        run_op(3'd5, 1'b1, 8'h0F, 8'h55, 8'hF0, 1'b1, 1'b0, 1'b0);  // NOT
        run_op(3'd2, 1'b0, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0);  // AND
        run_op(3'd3, 1'b1, 8'h50, 8'h0A, 8'h5A, 1'b0, 1'b0, 1'b0);  // OR
        run_op(3'd7, 1'b0, 8'h12, 8'h34, 8'h00, 1'b0, 1'b0, 1'b1);  // CLR
        run_op(3'd1, 1'b1, 8'hFF, 8'h77, 8'h00, 1'b0, 1'b1, 1'b1);  // INC wrap

        // start held for 10 cycles: accepted only in cycles 0 and 5.
        @(posedge clk); #1;
        start = 1'b1; func = 3'd4; dest = 1'b0; b_in = 8'hAA; c_in = 8'hAA;
        sbq.push_back('{d: 1'b0, r: 8'h00, s: 1'b0, c: 1'b0, z: 1'b1});
        sbq.push_back('{d: 1'b0, r: 8'h00, s: 1'b0, c: 1'b0, z: 1'b1});
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk); #1;
            chk($sformatf("hold_done_c%0d", k), 32'(done),  32'(k == 4 || k == 9));
            chk($sformatf("hold_sel_c%0d", k),  32'(sel_b), 32'(k == 1 || k == 6));
            chk($sformatf("hold_ld_c%0d", k),   32'(ld_a),  32'(k == 3 || k == 8));
        end
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("hold_no_third", 32'({sel_b, busy}), 32'd0);

        // Reset during COMPUTE aborts the instruction; restart right after.
        @(posedge clk); #1;
        start = 1'b1; func = 3'd0; dest = 1'b0; b_in = 8'h10; c_in = 8'h20;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk_all_zero("abort");
        reset = 1'b0;
        start = 1'b1; func = 3'd0; dest = 1'b1; b_in = 8'h10; c_in = 8'h20;
        sbq.push_back('{d: 1'b1, r: 8'h30, s: 1'b0, c: 1'b0, z: 1'b0});
        follow(1'b1, 8'h30);

        repeat (4) @(posedge clk);
        #1 chk("sb_drained", 32'(sbq.size()), 32'd0);
        chk("end_pend", 32'(pend_valid), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
